nrdiv8_core_seq: RTL and testbench
==================================

Name: nrdiv8_core_seq

Overview:
Sequential radix-2 non-restoring integer divider. It is the inverse-operation companion to the 8-bit Booth multiplier core and shares the same start/done handshake and sign_mode convention. It sits beside the multiplier in the arithmetic unit and produces a quotient, a remainder, and exception flags with a fixed latency.

Parameters:
WIDTH, 8, operand/result width in bits; all widths below derive from it.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in S_IDLE
dividend  in  WIDTH  numerator
divisor  in  WIDTH  denominator
sign_mode  in  2  [1]=dividend signed, [0]=divisor signed
quotient  out  WIDTH  low WIDTH bits of true quotient (two's complement)
remainder  out  WIDTH  remainder, sign of dividend
busy  out  1  high in any state except S_IDLE
done  out  1  one-cycle pulse, results valid
div_by_zero  out  1  divisor==0 for the completed op; valid with done, held
overflow  out  1  true quotient not representable; valid with done, held

Behaviour:
- Reset (rst_n low at a clk edge): state=S_IDLE; quotient, remainder, done, busy, div_by_zero, overflow all 0; internal registers cleared. Reset mid-operation aborts the op with no done pulse.
- Result type: signed if sign_mode!=2'b00, otherwise unsigned. Signed range is [-2^(W-1), 2^(W-1)-1]; unsigned range is [0, 2^W-1].
- States:
  - S_IDLE: on start, latch |dividend| and |divisor| as W-bit unsigned magnitudes (abs taken only when the operand's sign bit is set and its mode bit is 1). Also latch q_neg = sign(dividend) XOR sign(divisor), r_neg = sign(dividend), and dz = (divisor==0). Clear partial remainder P (W+1 bits). iter=W. Go to S_ITER.
  - S_ITER (W cycles): shift {P,Q} left 1. If P>=0, P=P-D; else P=P+D. New Q lsb = ~P_sign. Decrement iter. When iter reaches 1, go to S_FIX.
  - S_FIX (1 cycle): if P<0, P=P+D. Go to S_SIGN.
  - S_SIGN (1 cycle):
    - Normal case: quotient = q_neg ? -Q : Q; remainder = r_neg ? -P : P.
    - If dz: quotient = all ones, remainder = dividend (raw), div_by_zero=1, overflow=0.
    - Else overflow = true quotient outside range of result type.
    - Pulse done=1. Go to S_IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E(W+2), i.e. 10 cycles for W=8. Latency is fixed for all cases, including divide-by-zero.
- done is high for exactly one cycle. busy falls at the same edge that raises done.
- start while busy is ignored: no queuing, and no effect on the in-flight op.
- start in the same cycle done is high is accepted (the FSM is in S_IDLE). Back-to-back throughput is one op per W+2 cycles.
- Output registers change only in S_SIGN and at reset; they hold between operations.
- Overflow cases:
  - Signed -2^(W-1) / -1 gives quotient 0x80, remainder 0, overflow=1.
  - sign_mode=01 with dividend 255 and divisor -1 gives true result -255: quotient 0x01, overflow=1.
- Remainder always fits, because |r| <= |dividend| and r carries the dividend's sign.
- Magnitude of -2^(W-1) is 2^(W-1), held as unsigned W-bit with no loss.

Decomposition:
- Shared arithmetic include, alongside the existing Booth function header:
  - state encodings S_IDLE/S_ITER/S_FIX/S_SIGN (2-bit)
  - f_abs(value, sign_en): W-bit magnitude
  - f_cneg(value, neg): conditional two's complement
  - f_in_range(mag, neg, signed_res): overflow check
- One natural combinational sub-module: nrdiv_step, a single add/subtract-and-shift step on (P, Q, D). It returns the next P and the next Q, and can be reused by an unrolled variant.

Test Plan:
- sign_mode=00, 100/7, start pulse -> done exactly 10 cycles later; quotient=14, remainder=2, flags 0, busy high for 10 cycles.
- sign_mode=11, -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); also 100/-7 -> 0xF2 / 0x02; -100/-7 -> 0x0E / 0xFE.
- sign_mode=11, -128/-1 -> quotient=0x80, remainder=0, overflow=1. sign_mode=01, 255/-1 -> quotient=0x01, overflow=1.
- Divisor 0 with dividend 0x5A, any mode -> quotient=0xFF, remainder=0x5A, div_by_zero=1, latency still 10.
- Second start pulse at cycle 3 of an op -> ignored; first result correct. New start on the done cycle -> accepted, second done 10 cycles later.
- rst_n low at cycle 5 of an op -> no done; all outputs 0 and busy 0 on the next cycle; a fresh op completes correctly afterwards. Random sweep of all 65536 operand pairs x 4 modes versus the reference model.

Source files
------------

// File: rtl/nrdiv8_core_seq_pkg.sv
// Shared arithmetic definitions for the sequential non-restoring divider:
// FSM encodings, result payload and sign/magnitude helpers.
package nrdiv8_core_seq_pkg;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_SIGN = 2'd3;

  typedef logic [DIV_W-1:0] word_t;

  // Largest magnitude a negative signed result may carry (2^(W-1)).
  localparam word_t NEG_LIMIT = {1'b1, {(DIV_W-1){1'b0}}};

  typedef struct packed {
    word_t quotient;
    word_t remainder;
    logic  div_by_zero;
    logic  overflow;
  } div_result_t;

  function automatic word_t f_cneg(input word_t value, input logic neg);
    return neg ? word_t'((~value) + word_t'(1)) : value;
  endfunction

  // Magnitude of -2^(W-1) is 2^(W-1), which still fits as unsigned W bits.
  function automatic word_t f_abs(input word_t value, input logic sign_en);
    return f_cneg(value, sign_en & value[DIV_W-1]);
  endfunction

  function automatic logic f_in_range(input word_t mag, input logic neg,
                                      input logic signed_res);
    logic ok;
    if (signed_res) begin
      ok = neg ? (mag <= NEG_LIMIT) : (mag < NEG_LIMIT);
    end else begin
      ok = !neg || (mag == '0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/nrdiv8_core_seq_step.sv
// One non-restoring iteration: shift {P,Q} left, add or subtract D by the
// sign of the incoming P, and shift in the new quotient bit.
module nrdiv8_core_seq_step
  import nrdiv8_core_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next_c,
  output logic [WIDTH-1:0] q_next_c
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] d_ext;

  // Modular W+1-bit arithmetic is safe: the settled P always lies in [-D, D).
  always_comb begin
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    d_ext   = {1'b0, d};
    if (p[WIDTH]) begin
      p_next_c = p_shift + d_ext;
    end else begin
      p_next_c = p_shift - d_ext;
    end
    q_next_c = {q[WIDTH-2:0], ~p_next_c[WIDTH]};
  end

endmodule

// File: rtl/nrdiv8_core_seq.sv
// Sequential radix-2 non-restoring divider with start/done handshake,
// fixed W+2 cycle latency, signed/unsigned operand selection and flags.
module nrdiv8_core_seq
  import nrdiv8_core_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned IW = $clog2(WIDTH + 1);

  logic [1:0]       state,      state_nxt;
  logic [IW-1:0]    iter,       iter_nxt;
  logic [WIDTH:0]   p_reg,      p_nxt;
  logic [WIDTH-1:0] q_reg,      q_nxt;
  logic [WIDTH-1:0] d_reg,      d_nxt;
  logic [WIDTH-1:0] dvd_raw,    dvd_nxt;
  logic             q_neg,      q_neg_nxt;
  logic             r_neg,      r_neg_nxt;
  logic             dz,         dz_nxt;
  logic             signed_res, signed_nxt;
  logic             busy_r,     busy_nxt;
  logic             done_r,     done_nxt;
  div_result_t      res,        res_nxt;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   step_p_c;
  logic [WIDTH-1:0] step_q_c;

  nrdiv8_core_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p        (p_reg),
    .q        (q_reg),
    .d        (d_reg),
    .p_next_c (step_p_c),
    .q_next_c (step_q_c)
  );

  // Next-state and next-register logic.
  always_comb begin
    state_nxt  = state;
    iter_nxt   = iter;
    p_nxt      = p_reg;
    q_nxt      = q_reg;
    d_nxt      = d_reg;
    dvd_nxt    = dvd_raw;
    q_neg_nxt  = q_neg;
    r_neg_nxt  = r_neg;
    dz_nxt     = dz;
    signed_nxt = signed_res;
    busy_nxt   = busy_r;
    done_nxt   = 1'b0;
    res_nxt    = res;
    dvd_neg    = sign_mode[1] & dividend[WIDTH-1];
    dvs_neg    = sign_mode[0] & divisor[WIDTH-1];

    case (state)
      S_IDLE: begin
        if (start) begin
          q_nxt      = f_abs(dividend, sign_mode[1]);
          d_nxt      = f_abs(divisor, sign_mode[0]);
          dvd_nxt    = dividend;
          p_nxt      = '0;
          q_neg_nxt  = dvd_neg ^ dvs_neg;
          r_neg_nxt  = dvd_neg;
          dz_nxt     = (divisor == '0);
          signed_nxt = |sign_mode;
          iter_nxt   = IW'(WIDTH);
          busy_nxt   = 1'b1;
          state_nxt  = S_ITER;
        end
      end

      S_ITER: begin
        p_nxt    = step_p_c;
        q_nxt    = step_q_c;
        iter_nxt = iter - IW'(1);
        if (iter == IW'(1)) begin
          state_nxt = S_FIX;
        end
      end

      // Restore a negative partial remainder; the quotient bits are final.
      S_FIX: begin
        if (p_reg[WIDTH]) begin
          p_nxt = p_reg + {1'b0, d_reg};
        end
        state_nxt = S_SIGN;
      end

      S_SIGN: begin
        if (dz) begin
          res_nxt.quotient    = '1;
          res_nxt.remainder   = dvd_raw;
          res_nxt.div_by_zero = 1'b1;
          res_nxt.overflow    = 1'b0;
        end else begin
          res_nxt.quotient    = f_cneg(q_reg, q_neg);
          res_nxt.remainder   = f_cneg(p_reg[WIDTH-1:0], r_neg);
          res_nxt.div_by_zero = 1'b0;
          res_nxt.overflow    = !f_in_range(q_reg, q_neg, signed_res);
        end
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      iter       <= '0;
      p_reg      <= '0;
      q_reg      <= '0;
      d_reg      <= '0;
      dvd_raw    <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      dz         <= 1'b0;
      signed_res <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      res        <= '0;
    end else begin
      state      <= state_nxt;
      iter       <= iter_nxt;
      p_reg      <= p_nxt;
      q_reg      <= q_nxt;
      d_reg      <= d_nxt;
      dvd_raw    <= dvd_nxt;
      q_neg      <= q_neg_nxt;
      r_neg      <= r_neg_nxt;
      dz         <= dz_nxt;
      signed_res <= signed_nxt;
      busy_r     <= busy_nxt;
      done_r     <= done_nxt;
      res        <= res_nxt;
    end
  end

  assign quotient    = res.quotient;
  assign remainder   = res.remainder;
  assign div_by_zero = res.div_by_zero;
  assign overflow    = res.overflow;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_nrdiv8_core_seq.sv
// Scoreboard bench for nrdiv8_core_seq: directed operands with hand-computed
// results; a negedge monitor checks every done pulse against the queue.
module tb_nrdiv8_core_seq;

  localparam int unsigned W   = 8;
  localparam int          LAT = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [1:0]   sign_mode;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           issue_cyc;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_run = 0;

  nrdiv8_core_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_mode   (sign_mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_run++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, ".quotient"},    32'(quotient),    32'(e.q));
        check({e.tag, ".remainder"},   32'(remainder),   32'(e.r));
        check({e.tag, ".div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
        check({e.tag, ".overflow"},    32'(overflow),    32'(e.ov));
        check({e.tag, ".latency"},     32'(cyc - e.issue_cyc), 32'(LAT));
        check({e.tag, ".busy_cycles"}, 32'(busy_run),    32'(LAT));
        check({e.tag, ".busy_at_done"}, 32'(busy),       32'd0);
      end
      busy_run = 0;
    end else if (busy !== 1'b1) begin
      busy_run = 0;
    end
  end

  // Drive one start pulse from a negedge; the sampling posedge follows.
  task automatic issue(input string tag, input logic [1:0] m,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eov);
    exp_t e;
    sign_mode   = m;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    e.q         = eq;
    e.r         = er;
    e.dz        = edz;
    e.ov        = eov;
    e.issue_cyc = cyc + 1;
    e.tag       = tag;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [1:0] m,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic edz, input logic eov);
    issue(tag, m, a, b, eq, er, edz, eov);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    sign_mode = 2'b00;
    repeat (3) @(negedge clk);
    check("rst.quotient",    32'(quotient),    32'd0);
    check("rst.remainder",   32'(remainder),   32'd0);
    check("rst.busy",        32'(busy),        32'd0);
    check("rst.done",        32'(done),        32'd0);
    check("rst.div_by_zero", 32'(div_by_zero), 32'd0);
    check("rst.overflow",    32'(overflow),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // tag, mode, dividend, divisor, quotient, remainder, dz, ov
    run("u100_7",    2'b00, 8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0);
    run("s-100_7",   2'b11, 8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0);
    run("s100_-7",   2'b11, 8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0);
    run("s-100_-7",  2'b11, 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0);
    run("s-128_-1",  2'b11, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1);
    run("m01_255_-1", 2'b01, 8'hFF, 8'hFF,  8'h01, 8'h00, 1'b0, 1'b1);
    run("dz_m00",    2'b00, 8'h5A,  8'h00,  8'hFF, 8'h5A, 1'b1, 1'b0);
    run("dz_m01",    2'b01, 8'h5A,  8'h00,  8'hFF, 8'h5A, 1'b1, 1'b0);
    run("dz_m10",    2'b10, 8'h5A,  8'h00,  8'hFF, 8'h5A, 1'b1, 1'b0);
    run("dz_m11",    2'b11, 8'h5A,  8'h00,  8'hFF, 8'h5A, 1'b1, 1'b0);
    run("dz_neg",    2'b11, 8'h9C,  8'h00,  8'hFF, 8'h9C, 1'b1, 1'b0);
    run("u255_1",    2'b00, 8'hFF,  8'h01,  8'hFF, 8'h00, 1'b0, 1'b0);
    run("u7_100",    2'b00, 8'd7,   8'd100, 8'h00, 8'h07, 1'b0, 1'b0);
    run("u200_13",   2'b00, 8'd200, 8'd13,  8'h0F, 8'h05, 1'b0, 1'b0);
    run("s-128_1",   2'b11, 8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0);
    run("m10_-10_200", 2'b10, 8'hF6, 8'hC8, 8'h00, 8'hF6, 1'b0, 1'b0);
    run("s127_-128", 2'b11, 8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0);
    run("m01_200_-3", 2'b01, 8'hC8, 8'hFD,  8'hBE, 8'h02, 1'b0, 1'b0);

    // Start while busy must be ignored.
    issue("busy_ign", 2'b00, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    sign_mode = 2'b11;
    dividend  = 8'h80;
    divisor   = 8'h03;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start on the done cycle is accepted.
    issue("b2b_a", 2'b00, 8'd200, 8'd13, 8'h0F, 8'h05, 1'b0, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 32'(done), 32'd1);
    issue("b2b_b", 2'b11, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
    drain();

    // Reset in cycle 5 of an op aborts it without a done pulse.
    issue("abort", 2'b00, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort.quotient",    32'(quotient),    32'd0);
    check("abort.remainder",   32'(remainder),   32'd0);
    check("abort.busy",        32'(busy),        32'd0);
    check("abort.done",        32'(done),        32'd0);
    check("abort.div_by_zero", 32'(div_by_zero), 32'd0);
    check("abort.overflow",    32'(overflow),    32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run("post_abort", 2'b11, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);

    // Results hold while idle.
    repeat (3) @(negedge clk);
    check("hold.quotient", 32'(quotient), 32'h80);
    check("hold.overflow", 32'(overflow), 32'd1);
    check("hold.busy",     32'(busy),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
